cnt_sample_fifo: RTL
====================

CNT_SAMPLE_FIFO -- requirements
Module: cnt_sample_fifo

Interface
REQ-001 Parameter: DEPTH, 8, number of FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter: W, 4, sample width; SHALL match the upstream binary counter output width.
REQ-003 Port: clk  input  1  single system clock; all state SHALL update on posedge clk.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; rst=0 SHALL clear all state immediately, independent of clk.
REQ-005 Port: cnt_in  input  W  counter value from the upstream binary counter wrapper.
REQ-006 Port: sample_en  input  1  push request; sample cnt_in at this clock edge.
REQ-007 Port: out_data  output  W  sample at the FIFO head.
REQ-008 Port: out_valid  output  1  out_data holds a valid sample.
REQ-009 Port: out_ready  input  1  consumer accepts the head sample.
REQ-010 Port: level  output  5  current number of stored entries, 0..DEPTH.
REQ-011 Port: full  output  1  level==DEPTH.
REQ-012 Port: drop_cnt  output  8  count of rejected pushes, saturating.

Function
REQ-013 A pop SHALL occur on a posedge when out_valid=1 and out_ready=1; the head advances by one entry.
REQ-014 A push SHALL occur on a posedge when sample_en=1 and either full=0 or a pop occurs in the same cycle; cnt_in is written at the tail.
REQ-015 A push with full=1 and no same-cycle pop SHALL be dropped: FIFO contents are unchanged and drop_cnt increments by 1.
REQ-016 drop_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-017 Pushed data SHALL appear on out_data with out_valid=1 one cycle after the push edge when the FIFO was empty; there is no combinational path from cnt_in to out_data.
REQ-018 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 With the FIFO empty, sample_en=1 and out_ready=1 in the same cycle SHALL push only; no pop occurs because out_valid=0.
REQ-020 level SHALL update as follows: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full and empty SHALL be derived from level, not from pointer equality alone.
REQ-022 Samples SHALL be delivered in push order with no duplication or loss, except drops per REQ-015.
REQ-023 out_valid SHALL equal (level!=0); full SHALL equal (level==DEPTH); both are registered-state derived.

Reset
REQ-024 While rst=0: level=0, pointers=0, out_valid=0, full=0, drop_cnt=0, out_data=0.
REQ-025 Reset asserted mid-operation SHALL discard all stored samples; the first posedge after rst returns to 1 SHALL act as a normal cycle from the empty state.
REQ-026 Memory array contents need not be reset; out_data SHALL read 0 whenever out_valid=0.

Configuration
REQ-027 Macro CNT_FIFO_OVF_FLAG_EN: when defined, the block SHALL add output port ovf (1 bit), set on the first dropped push and held until reset (sticky).
REQ-028 When CNT_FIFO_OVF_FLAG_EN is undefined, port ovf SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then push cnt_in=3 with out_ready=0 -> next cycle out_valid=1, out_data=3, level=1.
REQ-030 DEPTH=8: push 0..7 on consecutive cycles with out_ready=0 -> full=1, level=8; a 9th push of 8 -> drop_cnt=1, contents 0..7 intact, ovf=1 if the macro is defined.
REQ-031 Full FIFO, sample_en=1 with cnt_in=9 and out_ready=1 together -> 0 is popped, 9 is accepted, level stays 8, drop_cnt is unchanged.
REQ-032 Continuous push of the counter sequence 0..15 with out_ready=1 -> the consumer sees 0..15 in order with 1-cycle latency, level<=1, pointers wrap.
REQ-033 Hold full=1 and sample_en=1 for 300 cycles -> drop_cnt=255 (saturated).
REQ-034 Level=5, assert rst=0 between clock edges -> out_valid=0, level=0, drop_cnt=0 immediately; after release, push 7 -> out_data=7 next cycle.

Source files
------------

// File: rtl/cnt_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// cnt_sample_fifo_if
//
// Purpose: groups the producer (counter sampling) and consumer (head read)
// signals of cnt_sample_fifo into one bundle.
//
// Handshake semantics:
//   Producer side: sample_en is a push request and has no ready.
//     A push is accepted on a clock edge when the FIFO is not full, or when a
//     pop happens on the same edge. Otherwise the push is dropped and counted
//     in drop_cnt.
//   Consumer side: strict valid/ready.
//     A transfer (pop) happens on a clock edge exactly when out_valid and
//     out_ready are both 1. out_data is held stable while out_valid=1 and
//     out_ready=0. out_valid does not depend on out_ready.
//
// Signals:
//   cnt_in    [W-1:0] counter value to sample
//   sample_en         push request
//   out_data  [W-1:0] sample at the FIFO head (0 when out_valid=0)
//   out_valid         head holds a valid sample
//   out_ready         consumer accepts the head sample
//   level     [4:0]   number of stored entries
//   full              level == DEPTH
//   drop_cnt  [7:0]   saturating count of rejected pushes
//
// Modports:
//   master - the surrounding logic (producer and consumer)
//   slave  - the FIFO itself
// -----------------------------------------------------------------------------
interface cnt_sample_fifo_if #(
    parameter int W = 4
);
    logic [W-1:0] cnt_in;
    logic         sample_en;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   level;
    logic         full;
    logic [7:0]   drop_cnt;

    modport master (
        output cnt_in, sample_en, out_ready,
        input  out_data, out_valid, level, full, drop_cnt
    );

    modport slave (
        input  cnt_in, sample_en, out_ready,
        output out_data, out_valid, level, full, drop_cnt
    );
endinterface

// File: rtl/cnt_sample_fifo.sv
// -----------------------------------------------------------------------------
// cnt_sample_fifo
//
// Purpose: a small synchronous FIFO that captures samples of an upstream
// binary counter. Pushes that arrive while the FIFO is full are dropped and
// counted in a saturating 8-bit counter. A pop on the same edge frees a slot,
// so a push on that edge is still accepted.
//
// Parameters:
//   DEPTH - number of entries; must be a power of two, 2..16
//   W     - sample width; must match the counter width
//
// Ports:
//   clk   - system clock; all state updates on its rising edge
//   rst   - asynchronous, active-low reset; clears all state except the
//           memory array
//   bus   - cnt_sample_fifo_if.slave (cnt_in, sample_en, out_data,
//           out_valid, out_ready, level, full, drop_cnt)
//   ovf   - sticky overflow flag. It is set by the first dropped push and
//           cleared only by reset. The port exists only when the macro
//           CNT_FIFO_OVF_FLAG_EN is defined.
//
// Optional feature macro: CNT_FIFO_OVF_FLAG_EN
// -----------------------------------------------------------------------------
module cnt_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cnt_sample_fifo_if.slave        bus
`ifdef CNT_FIFO_OVF_FLAG_EN
    ,
    output logic                    ovf
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level_q;
    logic [7:0]    drop_q;

    logic          not_empty;
    logic          is_full;
    logic          pop;
    logic          push;
    logic          drop;

    // Empty and full come from the occupancy count. Pointer equality alone
    // cannot tell an empty FIFO from a full one.
    assign not_empty = (level_q != 5'd0);
    assign is_full   = (level_q == 5'(DEPTH));

    // A pop on the same edge frees a slot, so a push into a full FIFO still
    // succeeds when the head is being consumed.
    assign pop  = not_empty && bus.out_ready;
    assign push = bus.sample_en && (!is_full || pop);
    assign drop = bus.sample_en && is_full && !pop;

    // Pointers and occupancy. The pointers wrap naturally because DEPTH is a
    // power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + 5'd1;
            end else if (pop && !push) begin
                level_q <= level_q - 5'd1;
            end
        end
    end

    // The storage array is not reset. Stale contents never reach out_data,
    // because out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.cnt_in;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

`ifdef CNT_FIFO_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    // The head is read from registered storage, so cnt_in has no
    // combinational path to out_data. A push into an empty FIFO appears on
    // out_data one cycle after the push edge.
    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? mem[rd_ptr] : '0;
    assign bus.level     = level_q;
    assign bus.full      = is_full;
    assign bus.drop_cnt  = drop_q;

endmodule
